// File: rtl/huff_pkg.sv
// Shared types and sizing for the Huffman front end: symbol-word layout and
// frequency-counter FSM states.
package huff_pkg;

  localparam int unsigned MAX_CHAR_COUNT = 3;
  localparam int unsigned FREQ_W         = 3;
  localparam int unsigned CHAR_W         = 8;
  localparam int unsigned SYM_W          = 1 + FREQ_W + CHAR_W;
  localparam int unsigned IDX_W          = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

  // Matches the encoder io_in layout {valid, freq, char}
  typedef struct packed {
    logic              valid;
    logic [FREQ_W-1:0] freq;
    logic [CHAR_W-1:0] sym_char;
  } huff_sym_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_WAIT    = 2'd2
  } huff_state_e;

endpackage

// File: rtl/huff_freq_counter_if.sv
// Character-stream input, encoder word output and status flags of the
// frequency counter; slave is the counter side.
interface huff_freq_counter_if;
  import huff_pkg::*;

  logic              char_valid;
  logic [CHAR_W-1:0] char_in;
  logic              char_last;
  logic              char_ready;
  logic              enc_done;
  logic [SYM_W-1:0]  out_word;
  logic              busy;
  logic              err_sat;
  logic              err_alphabet;

  modport master (
    output char_valid, char_in, char_last, enc_done,
    input  char_ready, out_word, busy, err_sat, err_alphabet
  );

  modport slave (
    input  char_valid, char_in, char_last, enc_done,
    output char_ready, out_word, busy, err_sat, err_alphabet
  );

endinterface

// File: rtl/huff_sym_table.sv
// Symbol slot table: parallel match, lowest-free-slot allocation and
// saturating counts. The read port sees the table as it will be after this cycle.
module huff_sym_table
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              inc_en_i,
  input  logic [CHAR_W-1:0] char_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              hit_c_o,
  output logic              full_c_o,
  output logic              sat_c_o,
  output huff_sym_t         rd_sym_c_o
);

  huff_sym_t slot_q [MAX_CHAR_COUNT];
  huff_sym_t slot_d [MAX_CHAR_COUNT];

  logic [MAX_CHAR_COUNT-1:0] match_vec;
  logic [MAX_CHAR_COUNT-1:0] used_vec;
  logic [IDX_W-1:0]          free_idx;
  logic [IDX_W-1:0]          hit_idx;
  logic [FREQ_W-1:0]         hit_freq;

  // Descending scan so the lowest free index wins
  always_comb begin
    match_vec = '0;
    used_vec  = '0;
    free_idx  = '0;
    hit_idx   = '0;
    hit_freq  = '0;
    for (int k = MAX_CHAR_COUNT - 1; k >= 0; k--) begin
      used_vec[k]  = slot_q[k].valid;
      match_vec[k] = slot_q[k].valid && (slot_q[k].sym_char == char_i);
      if (!slot_q[k].valid) free_idx = IDX_W'(k);
      if (match_vec[k]) begin
        hit_idx  = IDX_W'(k);
        hit_freq = slot_q[k].freq;
      end
    end
  end

  assign hit_c_o  = |match_vec;
  assign full_c_o = &used_vec;
  assign sat_c_o  = hit_c_o && (hit_freq == FREQ_MAX);

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      for (int k = 0; k < MAX_CHAR_COUNT; k++) slot_d[k] = '0;
    end else if (inc_en_i) begin
      if (hit_c_o) begin
        if (!sat_c_o) slot_d[hit_idx].freq = hit_freq + FREQ_W'(1);
      end else if (!full_c_o) begin
        slot_d[free_idx] = '{valid: 1'b1, freq: FREQ_W'(1), sym_char: char_i};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_CHAR_COUNT; k++) slot_q[k] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    rd_sym_c_o = '0;
    if (32'(rd_idx_i) < MAX_CHAR_COUNT) rd_sym_c_o = slot_d[rd_idx_i];
  end

endmodule

// File: rtl/huff_freq_counter.sv
// Frequency counter ahead of the Huffman encoder: counts a message, emits one
// word per table slot, then waits for the encoder before taking the next message.
module huff_freq_counter
  import huff_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  huff_freq_counter_if.slave   bus
);

  huff_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [SYM_W-1:0] out_q;
  logic             ready_q;
  logic             busy_q;
  logic             err_sat_q;
  logic             err_alpha_q;

  logic             accept_c;
  logic             clr_c;
  logic             hit_c;
  logic             full_c;
  logic             sat_c;
  logic [IDX_W-1:0] rd_idx_c;
  huff_sym_t        rd_sym_c;
  logic [SYM_W-1:0] emit_word_c;

  assign accept_c    = bus.char_valid && ready_q;
  assign clr_c       = (state_q == ST_WAIT) && bus.enc_done;
  // idx_q names the word currently on out_word, so prefetch the next slot
  assign rd_idx_c    = (state_q == ST_EMIT) ? (idx_q + IDX_W'(1)) : '0;
  assign emit_word_c = {1'b1, rd_sym_c.freq, rd_sym_c.sym_char};

  huff_sym_table u_table (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clr_c),
    .inc_en_i   (accept_c),
    .char_i     (bus.char_in),
    .rd_idx_i   (rd_idx_c),
    .hit_c_o    (hit_c),
    .full_c_o   (full_c),
    .sat_c_o    (sat_c),
    .rd_sym_c_o (rd_sym_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      out_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      err_sat_q   <= 1'b0;
      err_alpha_q <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept_c) begin
            if (sat_c) err_sat_q <= 1'b1;
            if (!hit_c && full_c) err_alpha_q <= 1'b1;
            if (bus.char_last) begin
              state_q <= ST_EMIT;
              idx_q   <= '0;
              out_q   <= emit_word_c;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (idx_q == IDX_W'(MAX_CHAR_COUNT - 1)) begin
            state_q <= ST_WAIT;
            out_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            out_q <= emit_word_c;
          end
        end
        ST_WAIT: begin
          if (bus.enc_done) begin
            state_q     <= ST_COLLECT;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_sat_q   <= 1'b0;
            err_alpha_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
          out_q   <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.char_ready   = ready_q;
  assign bus.out_word     = out_q;
  assign bus.busy         = busy_q;
  assign bus.err_sat      = err_sat_q;
  assign bus.err_alphabet = err_alpha_q;

endmodule

// File: tb/tb_huff_freq_counter.sv
// Bench for huff_freq_counter: message table plus hand-written reset and
// EMIT/WAIT corner sequences, emitted words checked through a scoreboard queue.
module tb_huff_freq_counter;
  import huff_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huff_freq_counter_if bus ();

  huff_freq_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [SYM_W-1:0] exp_q[$];

  typedef struct {
    string            msg;
    logic [SYM_W-1:0] w0;
    logic [SYM_W-1:0] w1;
    logic [SYM_W-1:0] w2;
    bit               sat;
    bit               alpha;
  } vec_t;

  function automatic logic [SYM_W-1:0] mk(input int f, input byte c);
    return {1'b1, FREQ_W'(f), CHAR_W'(c)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid output word must match the next expected word
  always @(negedge clk) begin
    if (!reset && bus.out_word[SYM_W-1]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h expected none", bus.out_word);
      end else begin
        check("out_word", 32'(bus.out_word), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_msg(input string m, input bit hold, input bit enc_emit,
                          input bit exp_sat, input bit exp_alpha);
    int t = 0;
    @(negedge clk);
    while (!bus.char_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_start", 32'(bus.char_ready), 32'(1));
    for (int i = 0; i < m.len(); i++) begin
      bus.char_valid = 1'b1;
      bus.char_in    = m[i];
      bus.char_last  = (i == m.len() - 1);
      @(negedge clk);
    end
    bus.char_valid = hold;
    bus.char_in    = "q";
    bus.char_last  = hold;
    for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
      check("emit_valid", 32'(bus.out_word[SYM_W-1]), 32'(1));
      check("emit_ready", 32'(bus.char_ready), 32'(0));
      check("emit_busy", 32'(bus.busy), 32'(1));
      bus.enc_done = enc_emit && (k == 0);
      @(negedge clk);
    end
    bus.enc_done = 1'b0;
    check("wait_word", 32'(bus.out_word), 32'(0));
    check("wait_busy", 32'(bus.busy), 32'(1));
    check("err_sat", 32'(bus.err_sat), 32'(exp_sat));
    check("err_alphabet", 32'(bus.err_alphabet), 32'(exp_alpha));
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    repeat (2) begin
      @(negedge clk);
      check("wait_ready", 32'(bus.char_ready), 32'(0));
    end
    bus.char_valid = 1'b0;
    bus.char_last  = 1'b0;
    bus.enc_done   = 1'b1;
    @(negedge clk);
    bus.enc_done = 1'b0;
    check("done_ready", 32'(bus.char_ready), 32'(1));
    check("done_busy", 32'(bus.busy), 32'(0));
    check("done_errs", 32'({bus.err_sat, bus.err_alphabet}), 32'(0));
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"anama",      mk(3, "a"), mk(1, "n"), mk(1, "m"), 1'b0, 1'b0};
    vecs[1] = '{"x",          mk(1, "x"), mk(0, 0),   mk(0, 0),   1'b0, 1'b0};
    vecs[2] = '{"aaaaaaaaab", mk(7, "a"), mk(1, "b"), mk(0, 0),   1'b1, 1'b0};
    vecs[3] = '{"abcda",      mk(2, "a"), mk(1, "b"), mk(1, "c"), 1'b0, 1'b1};

    reset          = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_in    = '0;
    bus.char_last  = 1'b0;
    bus.enc_done   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_word", 32'(bus.out_word), 32'(0));
    check("rst_ready", 32'(bus.char_ready), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_errs", 32'({bus.err_sat, bus.err_alphabet}), 32'(0));
    reset = 1'b0;

    foreach (vecs[v]) begin
      exp_q.push_back(vecs[v].w0);
      exp_q.push_back(vecs[v].w1);
      exp_q.push_back(vecs[v].w2);
      send_msg(vecs[v].msg, 1'b0, 1'b0, vecs[v].sat, vecs[v].alpha);
    end

    // Reset mid-message discards the partial table
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_in    = "a";
    @(negedge clk);
    bus.char_in    = "b";
    @(negedge clk);
    bus.char_valid = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_word", 32'(bus.out_word), 32'(0));
    check("mid_rst_ready", 32'(bus.char_ready), 32'(1));
    check("mid_rst_busy", 32'(bus.busy), 32'(0));
    exp_q.push_back(mk(1, "c"));
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(0, 0));
    send_msg("c", 1'b0, 1'b0, 1'b0, 1'b0);

    // enc_done during EMIT and char_valid held through EMIT/WAIT are both ignored
    exp_q.push_back(mk(1, "a"));
    exp_q.push_back(mk(1, "b"));
    exp_q.push_back(mk(0, 0));
    send_msg("ab", 1'b1, 1'b1, 1'b0, 1'b0);

    // Table must be empty again after enc_done
    exp_q.push_back(mk(1, "z"));
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(0, 0));
    send_msg("z", 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/huff_freq_counter.md
Name: huff_freq_counter

Overview:
Upstream stage of huff_encoder. Accepts a raw byte stream, one character per cycle, and builds a frequency table of up to MAX_CHAR_COUNT distinct symbols. On end-of-message it emits one packed word per table slot in the encoder's io_in format, {valid, freq[2:0], char[7:0]}. It then holds off new input until the downstream encoder signals that its vector is complete.

Parameters:
MAX_CHAR_COUNT, 3, number of table slots; equals the encoder's symbol count.
FREQ_W, 3, frequency field width; counts saturate at 2^FREQ_W-1.
CHAR_W, 8, character width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
char_valid  input  1  char_in is valid this cycle
char_in  input  CHAR_W  input character
char_last  input  1  last character of the message; qualified by char_valid
char_ready  output  1  block accepts a character this cycle
enc_done  input  1  one-cycle pulse from the encoder: vector finished, table may be cleared
out_word  output  1+FREQ_W+CHAR_W  {out_valid, freq, char}; drives encoder io_in[11:0]
busy  output  1  high in any state other than COLLECT
err_sat  output  1  sticky: a count saturated during the current message
err_alphabet  output  1  sticky: a character was dropped because the table was full

Behaviour:
- Reset:
  - state=COLLECT; all slots invalid, counts 0.
  - out_word=0, err_sat=0, err_alphabet=0, busy=0, char_ready=1.
  - Reset in any state aborts immediately; any partial emission is discarded.
- States: COLLECT -> EMIT -> WAIT -> COLLECT.
- A character is accepted when char_valid & char_ready.
- COLLECT, on each accepted character, compared against the registered table, which already reflects the previous cycle:
  - match in slot k: count[k] increments. If count[k] is already 2^FREQ_W-1 it holds and err_sat is set.
  - no match, free slot exists: allocate the lowest free index with count=1.
  - no match, table full: drop the character and set err_alphabet.
- An accepted character with char_last=1 is counted first; state goes to EMIT on the next cycle.
- char_last with char_valid=0 is ignored.
- EMIT:
  - char_ready=0.
  - Emits slot index 0..MAX_CHAR_COUNT-1, one per cycle, as out_word={1, count[k], char[k]}.
  - Unallocated slots are emitted as {1, 0, 0}.
  - Always exactly MAX_CHAR_COUNT valid words, back to back; there is no backpressure from the encoder.
- Latency: char_last accepted at cycle T -> out_word valid at T+1 .. T+MAX_CHAR_COUNT. At T+MAX_CHAR_COUNT+1, out_word[MSB]=0 and the state is WAIT.
- out_word is registered. When not emitting, the whole word is 0.
- WAIT:
  - char_ready=0, out_word=0.
  - On enc_done: clear the table, err_sat and err_alphabet; go to COLLECT with char_ready=1 on the next cycle.
  - enc_done in COLLECT or EMIT is ignored, not queued.
- busy = (state != COLLECT).
- Message boundaries: a message of a single character emits {1,1,c}, {1,0,0}, {1,0,0}. An empty message cannot occur, because last requires valid.

Decomposition:
- Shared package huff_pkg:
  - MAX_CHAR_COUNT, FREQ_W and CHAR_W defaults.
  - huff_sym_t struct {valid, freq, char}; its width matches the encoder io_in.
  - state enum {COLLECT, EMIT, WAIT}.
- One sub-module, huff_sym_table:
  - the slot registers, parallel compare, lowest-free-slot priority encoder and saturating increment;
  - outputs match/full flags and a read port indexed by emit counter.
- The top level holds the FSM, emit counter and output register.

Test Plan:
- Stream "a","n","a","m","a"(last) -> out_word words {1,3,8'h61}, {1,1,8'h6E}, {1,1,8'h6D}; no error flags; busy=1.
- Stream "x"(last) -> {1,1,8'h78}, {1,0,8'h00}, {1,0,8'h00}; out_word=0 on the fourth cycle; char_ready stays 0 until an enc_done pulse, then returns to 1 the next cycle.
- Nine "a" then "b"(last) -> {1,7,8'h61}, {1,1,8'h62}, {1,0,0}; err_sat=1.
- "a","b","c","d","a"(last) -> "d" dropped, err_alphabet=1; words {1,2,'a'}, {1,1,'b'}, {1,1,'c'}.
- Assert reset after 2 characters -> outputs 0, table empty; a fresh message "c"(last) emits {1,1,8'h63} first.
- enc_done pulsed during EMIT -> ignored; char_valid held high during EMIT/WAIT -> no counts change and char_ready stays 0.
